// File: rtl/normalizer_pkg.sv
// Register map, status/control bit positions and counter width shared by the normalizer CSR block.
package normalizer_pkg;

   localparam int REG_STATUS     = 0;
   localparam int REG_CTRL       = 1;
   localparam int REG_MAX_VALUE  = 2;
   localparam int REG_START_ADDR = 3;
   localparam int REG_STOP_ADDR  = 4;
   localparam int REG_CMD        = 5;
   localparam int REG_DONE_CNT   = 6;
   localparam int REG_AREA0      = 7;

   localparam int ST_IRQ         = 0;
   localparam int ST_BUSY        = 1;
   localparam int ST_ERR_BUSY    = 2;
   localparam int ST_ERR_RANGE   = 3;

   localparam int CTRL_IRQ_EN    = 0;
   localparam int CTRL_SQRT      = 1;

   localparam int DONE_CNT_W     = 16;
   localparam logic [DONE_CNT_W-1:0] DONE_CNT_MAX = '1;

endpackage

// File: rtl/normalizer_irq_ctrl.sv
// Completion interrupt: sticky pending bit with write-1-to-clear; a same-edge set beats the clear.
// One register stage for pending; irq output is a combinational mask, no backpressure.
module normalizer_irq_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   input  logic irq_en,
   output logic irq_pending,
   output logic irq
);

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_pending <= 1'b0;
      end else if (set) begin
         irq_pending <= 1'b1;
      end else if (clr) begin
         irq_pending <= 1'b0;
      end
   end

   // Masking leaves pending intact so software can poll it with irq_en low.
   assign irq = irq_pending & irq_en;

endmodule

// File: rtl/normalizer_csr.sv
// Avalon-MM CSR block for the normalizer: job config, busy-guarded start pulse, W1C interrupt.
// Writes land on the edge; reads return registered data one cycle later; the slave never stalls.
module normalizer_csr
   import normalizer_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int SAMPLE_W = 16,
   parameter int N_AREAS  = 4,
   parameter int ADDR_W   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            avs_s0_address,
   input  logic                         avs_s0_write,
   input  logic                         avs_s0_read,
   input  logic [DATA_W-1:0]            avs_s0_writedata,
   output logic [DATA_W-1:0]            avs_s0_readdata,
   output logic                         avs_s0_readdatavalid,
   output logic                         avm_s0_irq,
   input  logic                         done,
   output logic                         start,
   output logic                         busy,
   output logic                         sqrt_normal,
   output logic [SAMPLE_W-1:0]          max_value,
   output logic [DATA_W-1:0]            start_addr,
   output logic [DATA_W-1:0]            stop_addr,
   output logic [N_AREAS*SAMPLE_W-1:0]  area_lo,
   output logic [N_AREAS*SAMPLE_W-1:0]  area_hi
);

   logic [31:0]           addr;
   logic                  wr_en, rd_en, cfg_wr, cmd_wr, status_wr;
   logic                  range_ok, issue, done_evt, lock_viol;
   logic                  irq_en, irq_pending, err_busy, err_range;
   logic [DONE_CNT_W-1:0] done_cnt;
   logic [DATA_W-1:0]     rd_mux;

   assign addr      = 32'(avs_s0_address);
   assign wr_en     = avs_s0_write;
   assign rd_en     = avs_s0_read & ~avs_s0_write;
   assign cfg_wr    = wr_en & ~busy;
   assign cmd_wr    = wr_en && (addr == REG_CMD);
   assign status_wr = wr_en && (addr == REG_STATUS);
   assign range_ok  = stop_addr > start_addr;
   assign issue     = cmd_wr & ~busy & range_ok;
   assign done_evt  = done & busy;
   // Config space is frozen for the whole job; STATUS and DONE_CNT stay writable.
   assign lock_viol = wr_en & busy &
                      (((addr >= REG_CTRL) && (addr <= REG_STOP_ADDR)) || (addr >= REG_AREA0));

   always_ff @(posedge clk) begin
      if (rst) begin
         start                <= 1'b0;
         busy                 <= 1'b0;
         err_busy             <= 1'b0;
         err_range            <= 1'b0;
         irq_en               <= 1'b0;
         sqrt_normal          <= 1'b0;
         max_value            <= '0;
         start_addr           <= '0;
         stop_addr            <= '0;
         done_cnt             <= '0;
         avs_s0_readdata      <= '0;
         avs_s0_readdatavalid <= 1'b0;
      end else begin
         start <= issue;
         if (issue) begin
            busy <= 1'b1;
         end else if (done_evt) begin
            busy <= 1'b0;
         end

         if ((cmd_wr && busy) || lock_viol) begin
            err_busy <= 1'b1;
         end else if (status_wr && avs_s0_writedata[ST_ERR_BUSY]) begin
            err_busy <= 1'b0;
         end

         if (cmd_wr && !busy && !range_ok) begin
            err_range <= 1'b1;
         end else if (status_wr && avs_s0_writedata[ST_ERR_RANGE]) begin
            err_range <= 1'b0;
         end

         if (cfg_wr) begin
            case (addr)
               REG_CTRL: begin
                  irq_en      <= avs_s0_writedata[CTRL_IRQ_EN];
                  sqrt_normal <= avs_s0_writedata[CTRL_SQRT];
               end
               REG_MAX_VALUE:  max_value  <= avs_s0_writedata[SAMPLE_W-1:0];
               REG_START_ADDR: start_addr <= avs_s0_writedata;
               REG_STOP_ADDR:  stop_addr  <= avs_s0_writedata;
               default: ;
            endcase
         end

         // A clear that coincides with a completion still counts that completion.
         if (wr_en && (addr == REG_DONE_CNT)) begin
            done_cnt <= done_evt ? DONE_CNT_W'(1) : '0;
         end else if (done_evt && (done_cnt != DONE_CNT_MAX)) begin
            done_cnt <= done_cnt + DONE_CNT_W'(1);
         end

         avs_s0_readdatavalid <= rd_en;
         if (rd_en) begin
            avs_s0_readdata <= rd_mux;
         end
      end
   end

   for (genvar k = 0; k < N_AREAS; k++) begin : g_area
      logic [SAMPLE_W-1:0] lo_q, hi_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
         end else if (cfg_wr && (addr == 32'(REG_AREA0 + k))) begin
            lo_q <= avs_s0_writedata[SAMPLE_W-1:0];
            hi_q <= avs_s0_writedata[16 +: SAMPLE_W];
         end
      end

      assign area_lo[k*SAMPLE_W +: SAMPLE_W] = lo_q;
      assign area_hi[k*SAMPLE_W +: SAMPLE_W] = hi_q;
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         REG_STATUS: begin
            rd_mux[ST_IRQ]       = irq_pending;
            rd_mux[ST_BUSY]      = busy;
            rd_mux[ST_ERR_BUSY]  = err_busy;
            rd_mux[ST_ERR_RANGE] = err_range;
         end
         REG_CTRL: begin
            rd_mux[CTRL_IRQ_EN] = irq_en;
            rd_mux[CTRL_SQRT]   = sqrt_normal;
         end
         REG_MAX_VALUE:  rd_mux[SAMPLE_W-1:0]   = max_value;
         REG_START_ADDR: rd_mux                 = start_addr;
         REG_STOP_ADDR:  rd_mux                 = stop_addr;
         REG_DONE_CNT:   rd_mux[DONE_CNT_W-1:0] = done_cnt;
         default: begin
            for (int i = 0; i < N_AREAS; i++) begin
               if (addr == 32'(REG_AREA0 + i)) begin
                  rd_mux[SAMPLE_W-1:0]   = area_lo[i*SAMPLE_W +: SAMPLE_W];
                  rd_mux[16 +: SAMPLE_W] = area_hi[i*SAMPLE_W +: SAMPLE_W];
               end
            end
         end
      endcase
   end

   normalizer_irq_ctrl u_irq (
      .clk         (clk),
      .rst         (rst),
      .set         (done_evt),
      .clr         (status_wr && avs_s0_writedata[ST_IRQ]),
      .irq_en      (irq_en),
      .irq_pending (irq_pending),
      .irq         (avm_s0_irq)
   );

endmodule

// File: tb/tb_normalizer_csr.sv
// Bench for normalizer_csr: directed register-map scenarios then random bus/done traffic,
// compared against a register-level model; read data goes through a scoreboard queue.
module tb_normalizer_csr;

   localparam int DATA_W   = 32;
   localparam int SAMPLE_W = 16;
   localparam int N_AREAS  = 4;
   localparam int ADDR_W   = 4;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic [ADDR_W-1:0]           addr = '0;
   logic                        wr = 1'b0, rd = 1'b0, done = 1'b0;
   logic [DATA_W-1:0]           wdata = '0;
   logic [DATA_W-1:0]           rdata;
   logic                        rvalid, irq, start, busy, sqrt_normal;
   logic [SAMPLE_W-1:0]         max_value;
   logic [DATA_W-1:0]           start_addr, stop_addr;
   logic [N_AREAS*SAMPLE_W-1:0] area_lo, area_hi;

   always #5 clk = ~clk;

   normalizer_csr #(
      .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .N_AREAS(N_AREAS), .ADDR_W(ADDR_W)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .avs_s0_address       (addr),
      .avs_s0_write         (wr),
      .avs_s0_read          (rd),
      .avs_s0_writedata     (wdata),
      .avs_s0_readdata      (rdata),
      .avs_s0_readdatavalid (rvalid),
      .avm_s0_irq           (irq),
      .done                 (done),
      .start                (start),
      .busy                 (busy),
      .sqrt_normal          (sqrt_normal),
      .max_value            (max_value),
      .start_addr           (start_addr),
      .stop_addr            (stop_addr),
      .area_lo              (area_lo),
      .area_hi              (area_hi)
   );

   // Reference model state (values visible after the most recent clock edge).
   bit            m_busy, m_irq_pend, m_irq_en, m_sqrt, m_err_busy, m_err_range;
   bit            m_start_p, m_rvalid;
   logic [15:0]   m_max;
   logic [31:0]   m_start_a, m_stop_a, m_rd;
   int            m_cnt;
   logic [15:0]   m_lo [N_AREAS];
   logic [15:0]   m_hi [N_AREAS];
   logic [31:0]   exp_q [$];

   int n_vec = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input int a);
      logic [31:0] v;
      v = '0;
      if (a == 0)      v = {28'd0, m_err_range, m_err_busy, m_busy, m_irq_pend};
      else if (a == 1) v = {30'd0, m_sqrt, m_irq_en};
      else if (a == 2) v = {16'd0, m_max};
      else if (a == 3) v = m_start_a;
      else if (a == 4) v = m_stop_a;
      else if (a == 6) v = 32'(m_cnt);
      else if (a >= 7 && a < 7 + N_AREAS) v = {m_hi[a-7], m_lo[a-7]};
      return v;
   endfunction

   // Applies the register-map rules for one clock edge, using the inputs currently driven.
   task automatic model_apply();
      int a;
      bit dn;
      a = int'(addr);
      m_start_p = 1'b0;
      m_rvalid  = 1'b0;
      if (rst) begin
         {m_busy, m_irq_pend, m_irq_en, m_sqrt, m_err_busy, m_err_range} = '0;
         m_max = '0; m_start_a = '0; m_stop_a = '0; m_rd = '0; m_cnt = 0;
         for (int k = 0; k < N_AREAS; k++) begin
            m_lo[k] = '0;
            m_hi[k] = '0;
         end
         exp_q.delete();
      end else begin
         dn = done && m_busy;
         if (wr) begin
            if (a == 0) begin
               if (wdata[0]) m_irq_pend  = 1'b0;
               if (wdata[2]) m_err_busy  = 1'b0;
               if (wdata[3]) m_err_range = 1'b0;
            end else if (a == 5) begin
               if (m_busy) m_err_busy = 1'b1;
               else if (m_stop_a > m_start_a) begin
                  m_start_p = 1'b1;
                  m_busy    = 1'b1;
               end else m_err_range = 1'b1;
            end else if (a == 6) begin
               m_cnt = 0;
            end else if (m_busy) begin
               m_err_busy = 1'b1;
            end else if (a == 1) begin
               m_irq_en = wdata[0];
               m_sqrt   = wdata[1];
            end else if (a == 2) m_max = wdata[15:0];
            else if (a == 3) m_start_a = wdata;
            else if (a == 4) m_stop_a = wdata;
            else if (a >= 7 && a < 7 + N_AREAS) begin
               m_lo[a-7] = wdata[15:0];
               m_hi[a-7] = wdata[31:16];
            end
         end else if (rd) begin
            m_rd = model_read(a);
            exp_q.push_back(m_rd);
            m_rvalid = 1'b1;
         end
         if (dn) begin
            m_busy     = 1'b0;
            m_irq_pend = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
      end
   endtask

   always @(negedge clk) begin
      logic [63:0] e_lo, e_hi;
      if (mon_en) begin
         for (int k = 0; k < N_AREAS; k++) begin
            e_lo[k*16 +: 16] = m_lo[k];
            e_hi[k*16 +: 16] = m_hi[k];
         end
         chk("start",       64'(start),       64'(m_start_p));
         chk("busy",        64'(busy),        64'(m_busy));
         chk("irq",         64'(irq),         64'(m_irq_pend & m_irq_en));
         chk("sqrt_normal", 64'(sqrt_normal), 64'(m_sqrt));
         chk("max_value",   64'(max_value),   64'(m_max));
         chk("start_addr",  64'(start_addr),  64'(m_start_a));
         chk("stop_addr",   64'(stop_addr),   64'(m_stop_a));
         chk("area_lo",     area_lo,          e_lo);
         chk("area_hi",     area_hi,          e_hi);
         chk("readdatavalid", 64'(rvalid),    64'(m_rvalid));
         if (rvalid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL readdata at %0t: valid with no read outstanding, got %h", $time, rdata);
            end else begin
               chk("readdata", 64'(rdata), 64'(exp_q.pop_front()));
            end
         end else begin
            chk("readdata_hold", 64'(rdata), 64'(m_rd));
         end
      end
   end

   task automatic op(input bit w, input bit r, input int a, input logic [31:0] d,
                     input bit dn, input bit rs);
      wr = w; rd = r; addr = a[ADDR_W-1:0]; wdata = d; done = dn; rst = rs;
      @(posedge clk);
      model_apply();
      #1;
      wr = 1'b0; rd = 1'b0; done = 1'b0; rst = 1'b0;
   endtask

   task automatic wr_reg(input int a, input logic [31:0] d); op(1, 0, a, d, 0, 0); endtask
   task automatic rd_reg(input int a);                       op(0, 1, a, 0, 0, 0); endtask
   task automatic idle();                                    op(0, 0, 0, 0, 0, 0); endtask
   task automatic pulse_done();                              op(0, 0, 0, 0, 1, 0); endtask

   initial begin
      int          a, kind;
      logic [31:0] d;
      bit          dn, rs;

      op(0, 0, 0, 0, 0, 1);
      mon_en = 1'b1;
      op(0, 0, 0, 0, 0, 1);
      rd_reg(0); idle();

      // First job, then attempts to disturb it while busy.
      wr_reg(3, 32'h100); wr_reg(4, 32'h200); wr_reg(2, 32'h7FFF); wr_reg(5, 0);
      rd_reg(0); idle();
      wr_reg(5, 0); wr_reg(2, 32'h1234); rd_reg(0); wr_reg(0, 32'h4); rd_reg(0);
      pulse_done(); wr_reg(0, 32'hF);

      // Empty range is refused.
      wr_reg(3, 32'h200); wr_reg(5, 0); rd_reg(0); wr_reg(0, 32'h8);

      // Interrupt masking, set-beats-clear, lone clear, completion count.
      wr_reg(1, 0); wr_reg(4, 32'h300); wr_reg(5, 0); idle(); pulse_done(); idle();
      wr_reg(1, 32'h3); idle();
      wr_reg(5, 0); idle(); op(1, 0, 0, 32'h1, 1, 0); idle();
      wr_reg(0, 32'h1); idle(); rd_reg(6); rd_reg(1);

      // CMD coinciding with done, DONE_CNT clear coinciding with done.
      wr_reg(5, 0); op(1, 0, 5, 0, 1, 0); idle(); rd_reg(0);
      wr_reg(5, 0); op(1, 0, 6, 0, 1, 0); rd_reg(6);

      // Area registers, unmapped and CMD reads, write-priority on a joint access.
      wr_reg(10, 32'hABCD0123); rd_reg(10); rd_reg(11); rd_reg(5);
      op(1, 1, 2, 32'h55, 0, 0); rd_reg(2);

      // Reset in the middle of a job; a late done must be ignored.
      wr_reg(5, 0); idle(); op(0, 0, 0, 0, 0, 1); pulse_done(); rd_reg(0); rd_reg(6);

      for (int i = 0; i < 3000; i++) begin
         a    = int'($urandom_range(0, 15));
         kind = int'($urandom_range(0, 9));
         d    = $urandom;
         if (a == 3 || a == 4) d = $urandom_range(0, 15);
         dn = ($urandom_range(0, 4) == 0);
         rs = ($urandom_range(0, 399) == 0);
         op(kind < 3 || kind == 9, kind >= 3 && kind != 6 && kind != 7 && kind != 8 || kind == 9,
            a, d, dn, rs);
      end

      idle(); idle(); idle();
      chk("read_queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
